spi_word_target: RTL and testbench

- SPI mode-0 target that sits directly downstream of the host SPI master on the SCK/CS/COPI/CIPO pins.
- Deserialises 64-bit command words for the rapcore command decoder and serialises a 64-bit reply word back on CIPO.
- All pin inputs are asynchronous to CLK. The block synchronises them, detects edges, and presents one-cycle word strobes in the CLK domain.

---
 rtl/spi_word_target.sv | 219 +++++++++++++++++++++
 tb/tb_spi_word_target.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_target.sv
// SPI mode-0 target: deserialises WORD_BYTES-byte command words from COPI and serialises a reply word on CIPO.
// Optional feature: define SPI_ABORT_CNT_EN to add abort_cnt, a saturating count of discarded partial words.
module spi_word_target #(
  parameter int WORD_BYTES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    COPI,
  output logic                    CIPO,
  input  logic [8*WORD_BYTES-1:0] tx_word,
  output logic                    tx_load,
  output logic [8*WORD_BYTES-1:0] rx_word,
  output logic                    rx_valid,
  output logic                    busy
`ifdef SPI_ABORT_CNT_EN
  ,
  output logic [7:0]              abort_cnt
`endif
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BYTE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int IDX_W  = $clog2(WORD_W);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic                   r_prev_sck;
  logic                   r_prev_cs;

  logic [7:0]        r_rx_byte;
  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] r_byte_cnt;
  logic [WORD_W-1:0] r_rx_shadow;
  logic [WORD_W-1:0] r_shift_tx;
  logic              r_cipo;
  logic [WORD_W-1:0] r_rx_word;
  logic              r_rx_valid;
  logic              r_word_done;

  logic              w_sync_sck;
  logic              w_sync_cs;
  logic              w_sync_copi;
  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic              w_shift_rise;
  logic              w_byte_done;
  logic              w_word_done;
  logic              w_abort;
  logic              w_tx_load;
  logic [7:0]        w_rx_byte_nxt;
  logic [IDX_W-1:0]  w_tx_idx;

  assign w_sync_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_sync_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sync_copi = r_copi_sync[SYNC_STAGES-1];

  assign w_sck_rise =  w_sync_sck & ~r_prev_sck;
  assign w_sck_fall = ~w_sync_sck &  r_prev_sck;
  assign w_cs_rise  =  w_sync_cs  & ~r_prev_cs;
  assign w_cs_fall  = ~w_sync_cs  &  r_prev_cs;

  // A rise coinciding with CS release is dropped: the release wins.
  assign w_shift_rise  = (r_state == ST_SHIFT) && w_sck_rise && !w_cs_rise;
  assign w_byte_done   = w_shift_rise && (r_bit_cnt == 3'd7);
  assign w_word_done   = w_byte_done && (r_byte_cnt == LAST_BYTE);
  assign w_abort       = (r_state == ST_SHIFT) && w_cs_rise &&
                         ((r_bit_cnt != 3'd0) || (r_byte_cnt != '0));
  assign w_rx_byte_nxt = {r_rx_byte[6:0], w_sync_copi};

  // Reply bits go out in receive order: byte k ascending, bit 7 down to 0.
  assign w_tx_idx = IDX_W'({r_byte_cnt, ~r_bit_cnt});

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_tx_load   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SHIFT;
          w_tx_load   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) w_state_nxt = ST_IDLE;
        else if (w_word_done) w_tx_load = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (reset) w_tx_load = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_copi_sync <= '0;
      r_prev_sck  <= 1'b0;
      r_prev_cs   <= 1'b1;
      r_rx_byte   <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_rx_shadow <= '0;
      r_shift_tx  <= '0;
      r_cipo      <= 1'b0;
      r_rx_word   <= '0;
      r_rx_valid  <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples the values from before this edge.
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], COPI};
      r_prev_sck  <= w_sync_sck;
      r_prev_cs   <= w_sync_cs;

      // The last byte lands in the shadow on the completing edge; publish it one edge later.
      r_rx_valid  <= r_word_done;
      r_word_done <= w_word_done;
      if (r_word_done) r_rx_word <= r_rx_shadow;

      unique case (r_state)
        ST_IDLE: begin
          r_cipo     <= 1'b0;
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
        end
        ST_LOAD: begin
          if (w_cs_rise) begin
            r_cipo <= 1'b0;
          end else begin
            r_shift_tx <= tx_word;
            r_cipo     <= tx_word[7];
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_cipo     <= 1'b0;
            r_rx_byte  <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end else if (w_shift_rise) begin
            r_rx_byte <= w_rx_byte_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              for (int k = 0; k < WORD_BYTES; k++) begin
                if (r_byte_cnt == BYTE_W'(k)) r_rx_shadow[8*k +: 8] <= w_rx_byte_nxt;
              end
              if (w_word_done) begin
                r_byte_cnt <= '0;
                r_shift_tx <= tx_word;
              end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
              end
            end
          end else if (w_sck_fall) begin
            r_cipo <= r_shift_tx[w_tx_idx];
          end
        end
        default: r_cipo <= 1'b0;
      endcase
    end
  end

`ifdef SPI_ABORT_CNT_EN
  logic [7:0] r_abort_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_abort_cnt <= '0;
    end else if (w_abort && (r_abort_cnt != 8'hff)) begin
      r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign abort_cnt = r_abort_cnt;
`else
  logic w_unused_abort;
  assign w_unused_abort = w_abort;
`endif

  assign CIPO     = r_cipo;
  assign tx_load  = w_tx_load;
  assign rx_word  = r_rx_word;
  assign rx_valid = r_rx_valid;
  assign busy     = ~w_sync_cs;

endmodule

// File: tb/tb_spi_word_target.sv
// Directed bench for spi_word_target: single/back-to-back words, reply path, abort, mid-word reset, idle noise.
// Build with SPI_ABORT_CNT_EN defined to also exercise abort_cnt.
module tb_spi_word_target;

  localparam int W = 64;

  logic         CLK = 1'b0;
  logic         reset;
  logic         SCK;
  logic         CS;
  logic         COPI;
  logic         CIPO;
  logic [W-1:0] tx_word;
  logic         tx_load;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         busy;
`ifdef SPI_ABORT_CNT_EN
  logic [7:0]   abort_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int half  = 2;

  logic [W-1:0] rx_q[$];
  int   tx_load_cnt = 0;
  int   cipo_hi_cnt = 0;
  int   dbl_cnt     = 0;
  logic prev_valid  = 1'b0;
  int   q_base, tx_base, cipo_base, dbl_base;

  always #5 CLK = ~CLK;

  spi_word_target #(.WORD_BYTES(8), .SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .SCK      (SCK),
    .CS       (CS),
    .COPI     (COPI),
    .CIPO     (CIPO),
    .tx_word  (tx_word),
    .tx_load  (tx_load),
    .rx_word  (rx_word),
    .rx_valid (rx_valid),
    .busy     (busy)
`ifdef SPI_ABORT_CNT_EN
    ,
    .abort_cnt(abort_cnt)
`endif
  );

  // Output monitor, sampled away from the active edge.
  always @(negedge CLK) begin
    if (rx_valid) rx_q.push_back(rx_word);
    if (rx_valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
    prev_valid <= rx_valid;
    if (tx_load) tx_load_cnt <= tx_load_cnt + 1;
    if (CIPO) cipo_hi_cnt <= cipo_hi_cnt + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic mark();
    @(posedge CLK);
    q_base    = rx_q.size();
    tx_base   = tx_load_cnt;
    cipo_base = cipo_hi_cnt;
    dbl_base  = dbl_cnt;
    @(negedge CLK);
  endtask

  function automatic logic [W-1:0] rx_count();
    return W'(rx_q.size() - q_base);
  endfunction

  function automatic logic [W-1:0] rx_at(input int i);
    if (q_base + i < rx_q.size()) return rx_q[q_base + i];
    return {W{1'bx}};
  endfunction

  task automatic sck_bit(input logic b, output logic c);
    COPI = b;
    clk_n(half);
    SCK = 1'b1;
    c = CIPO;
    clk_n(half);
    SCK = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits, output logic [W-1:0] reply);
    logic c;
    reply = '0;
    for (int n = 0; n < nbits; n++) begin
      int k = n / 8;
      int i = 7 - (n % 8);
      sck_bit(w[8*k + i], c);
      reply[8*k + i] = c;
    end
  endtask

  task automatic cs_begin();
    CS = 1'b0;
    clk_n(8);
  endtask

  task automatic cs_end();
    clk_n(6);
    CS = 1'b1;
    clk_n(6);
  endtask

  logic [W-1:0] rep;
  logic [W-1:0] five_words[5];
  logic [W-1:0] rep_lo;

  initial begin
    five_words[0] = 64'h0a00000000000001;
    five_words[1] = 64'h0100000000000001;
    five_words[2] = 64'h00000000005fffff;
    five_words[3] = 64'h0100000000000000;
    five_words[4] = 64'h0000000000000000;

    reset = 1'b1; SCK = 1'b0; CS = 1'b1; COPI = 1'b0; tx_word = '0;
    clk_n(3);
    check("rst_cipo", W'(CIPO), 64'd0);
    check("rst_rx_word", rx_word, 64'd0);
    check("rst_rx_valid", W'(rx_valid), 64'd0);
    check("rst_tx_load", W'(tx_load), 64'd0);
    check("rst_busy", W'(busy), 64'd0);
`ifdef SPI_ABORT_CNT_EN
    check("rst_abort_cnt", W'(abort_cnt), 64'd0);
`endif
    reset = 1'b0;
    clk_n(4);

    // Single word at SCK = CLK/4.
    mark();
    cs_begin();
    check("busy_cs_low", W'(busy), 64'd1);
    send_bits(64'h0a00000000000001, 64, rep);
    cs_end();
    check("single_count", rx_count(), 64'd1);
    check("single_word", rx_at(0), 64'h0a00000000000001);
    check("single_tx_load", W'(tx_load_cnt - tx_base), 64'd2);
    check("busy_cs_high", W'(busy), 64'd0);

    // Five words in one CS assertion: tx_load at CS fall plus one per completed word.
    mark();
    cs_begin();
    for (int j = 0; j < 5; j++) send_bits(five_words[j], 64, rep);
    cs_end();
    check("b2b_count", rx_count(), 64'd5);
    for (int j = 0; j < 5; j++) check($sformatf("b2b_word%0d", j), rx_at(j), five_words[j]);
    check("b2b_tx_load", W'(tx_load_cnt - tx_base), 64'd6);
    check("b2b_no_double_valid", W'(dbl_cnt - dbl_base), 64'd0);

    // Reply path; slower SCK so CIPO settles within the low phase.
    half = 4;
    mark();
    tx_word = 64'h0123456789abcdef;
    cs_begin();
    tx_word = 64'hfedcba9876543210;
    send_bits(64'h1122334455667788, 64, rep);
    cs_end();
    rep_lo = {56'd0, rep[7:0]};
    check("reply_first_byte", rep_lo, 64'h00000000000000ef);
    check("reply_word", rep, 64'h0123456789abcdef);
    check("reply_rx_word", rx_at(0), 64'h1122334455667788);
    check("reply_cipo_idle", W'(CIPO), 64'd0);
    half = 2;

    // Abort after 3 bytes + 5 bits.
    mark();
    cs_begin();
    send_bits(64'hffffffffffffffff, 29, rep);
    cs_end();
    check("abort_count", rx_count(), 64'd0);
    check("abort_rx_hold", rx_word, 64'h1122334455667788);
    check("abort_cipo", W'(CIPO), 64'd0);
`ifdef SPI_ABORT_CNT_EN
    check("abort_cnt_inc", W'(abort_cnt), 64'd1);
`endif
    mark();
    cs_begin();
    send_bits(64'h0100000000000001, 64, rep);
    cs_end();
    check("post_abort_count", rx_count(), 64'd1);
    check("post_abort_word", rx_at(0), 64'h0100000000000001);

    // Reset pulse after 20 bits.
    mark();
    cs_begin();
    send_bits(64'haaaaaaaaaaaaaaaa, 20, rep);
    clk_n(1);
    reset = 1'b1;
    clk_n(1);
    check("midrst_rx_word", rx_word, 64'd0);
    check("midrst_cipo", W'(CIPO), 64'd0);
    check("midrst_rx_valid", W'(rx_valid), 64'd0);
    check("midrst_tx_load", W'(tx_load), 64'd0);
    check("midrst_busy", W'(busy), 64'd0);
    reset = 1'b0;
    CS = 1'b1;
    clk_n(6);
    check("midrst_no_valid", rx_count(), 64'd0);
`ifdef SPI_ABORT_CNT_EN
    check("midrst_abort_cnt", W'(abort_cnt), 64'd0);
`endif
    mark();
    cs_begin();
    send_bits(64'h00000000005fffff, 64, rep);
    cs_end();
    check("fresh_count", rx_count(), 64'd1);
    check("fresh_word", rx_at(0), 64'h00000000005fffff);

    // SCK and COPI activity with CS high must be ignored.
    mark();
    for (int j = 0; j < 16; j++) begin
      SCK = 1'b1;
      COPI = ~COPI;
      clk_n(2);
      SCK = 1'b0;
      clk_n(2);
    end
    clk_n(6);
    check("idle_no_valid", rx_count(), 64'd0);
    check("idle_no_tx_load", W'(tx_load_cnt - tx_base), 64'd0);
    check("idle_cipo_low", W'(cipo_hi_cnt - cipo_base), 64'd0);
    check("idle_busy", W'(busy), 64'd0);
    check("idle_rx_hold", rx_word, 64'h00000000005fffff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
